// File: rtl/fetch_if.sv
// Instruction-fetch bundle: memory request/response, redirect input and decoder-facing outputs.
interface fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] pc_plus2;
  logic        inst_ready;
  logic        halted;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus2, halted,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus2, halted,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM with redirect handling and HALT detection.
// One request in flight at a time; a redirect while it is in flight marks its response for discard.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_HALT} state_t;

  localparam logic [15:0] NOP_INST = 16'h0800;

  state_t      state, state_d;
  logic [15:0] pc, pc_d;
  logic        drop, drop_d;
  logic [15:0] inst_p1, inst_d;
  logic [15:0] inst_pc_p1, inst_pc_d;

  function automatic logic [15:0] pc_inc(input logic [15:0] a);
    return a + 16'd2;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      inst_p1    <= NOP_INST;
      inst_pc_p1 <= 16'h0000;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      drop       <= drop_d;
      inst_p1    <= inst_d;
      inst_pc_p1 <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    drop_d    = drop;
    inst_d    = inst_p1;
    inst_pc_d = inst_pc_p1;
    unique case (state)
      S_IDLE: begin
        state_d = S_ISSUE;
        if (bus.redirect) pc_d = bus.redirect_pc;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        if (bus.redirect) begin
          pc_d   = bus.redirect_pc;
          drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          // A stale or just-redirected response is thrown away and fetch restarts at pc.
          if (drop || bus.redirect) begin
            drop_d  = 1'b0;
            state_d = S_ISSUE;
            if (bus.redirect) pc_d = bus.redirect_pc;
          end else begin
            inst_d    = bus.imem_rdata;
            inst_pc_d = pc;
            pc_d      = pc_inc(pc);
            state_d   = S_OUT;
          end
        end else if (bus.redirect) begin
          pc_d   = bus.redirect_pc;
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = S_ISSUE;
        end else if (bus.inst_ready) begin
          state_d = (inst_p1[15:11] == 5'b00000) ? S_HALT : S_ISSUE;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_req   = (state == S_ISSUE);
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (state == S_OUT);
  assign bus.halted     = (state == S_HALT);
  assign bus.inst       = inst_p1;
  assign bus.inst_pc    = inst_pc_p1;
  assign bus.pc_plus2   = pc_inc(inst_pc_p1);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table of straight-line fetches plus redirect, halt, reset and wrap sequences.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_w = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_if a ();
  fetch_if b ();

  fetch_unit #(.RESET_PC(16'h0000)) dut   (.clk(clk), .rst_n(rst_n),   .bus(a.master));
  fetch_unit #(.RESET_PC(16'hFFFE)) dut_w (.clk(clk), .rst_n(rst_n_w), .bus(b.master));

  typedef struct {
    logic [15:0] addr;
    logic [15:0] rdata;
    int          lat;
    int          rdy_delay;
    logic [15:0] pc2;
  } vec_t;

  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] pc2;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[3];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req(input logic [15:0] exp_addr, input string name);
    int n = 0;
    while (!a.imem_req && n < 30) begin
      step();
      n++;
    end
    chk1({name, "_req"}, a.imem_req, 1'b1);
    chk({name, "_addr"}, a.imem_addr, exp_addr);
  endtask

  task automatic respond(input int lat, input logic [15:0] data);
    for (int i = 0; i < lat; i++) begin
      step();
      chk1("wait_no_valid", a.inst_valid, 1'b0);
    end
    a.imem_rvalid = 1'b1;
    a.imem_rdata  = data;
    step();
    a.imem_rvalid = 1'b0;
  endtask

  task automatic accept();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_underflow: got accept expected none");
    end else begin
      e = exp_q.pop_front();
      chk1("acc_valid", a.inst_valid, 1'b1);
      chk("acc_inst", a.inst, e.inst);
      chk("acc_inst_pc", a.inst_pc, e.pc);
      chk("acc_pc_plus2", a.pc_plus2, e.pc2);
    end
    a.inst_ready = 1'b1;
    step();
    a.inst_ready = 1'b0;
  endtask

  task automatic do_fetch(input vec_t v);
    wait_req(v.addr, "fetch");
    exp_q.push_back('{v.rdata, v.addr, v.pc2});
    respond(v.lat, v.rdata);
    chk1("out_valid", a.inst_valid, 1'b1);
    for (int i = 0; i < v.rdy_delay; i++) begin
      step();
      chk1("stall_valid", a.inst_valid, 1'b1);
      chk1("stall_no_req", a.imem_req, 1'b0);
      chk("stall_inst", a.inst, v.rdata);
      chk("stall_inst_pc", a.inst_pc, v.addr);
      chk("stall_pc_plus2", a.pc_plus2, v.pc2);
    end
    accept();
  endtask

  initial begin
    int t0;
    int n;
    a.imem_rvalid = 1'b0; a.imem_rdata = 16'h0; a.redirect = 1'b0;
    a.redirect_pc = 16'h0; a.inst_ready = 1'b0;
    b.imem_rvalid = 1'b0; b.imem_rdata = 16'h0; b.redirect = 1'b0;
    b.redirect_pc = 16'h0; b.inst_ready = 1'b0;

    vecs[0] = '{16'h0000, 16'h4000, 1, 0, 16'h0002};
    vecs[1] = '{16'h0002, 16'h4800, 1, 0, 16'h0004};
    vecs[2] = '{16'h0004, 16'h5123, 4, 5, 16'h0006};

    repeat (3) step();
    chk1("rst_req", a.imem_req, 1'b0);
    chk1("rst_valid", a.inst_valid, 1'b0);
    chk1("rst_halted", a.halted, 1'b0);
    chk("rst_inst", a.inst, 16'h0800);
    chk("rst_inst_pc", a.inst_pc, 16'h0000);
    chk("rst_addr", a.imem_addr, 16'h0000);
    rst_n = 1'b1;

    // Straight-line fetches, including the 3-cycle throughput measurement.
    t0 = 0;
    for (int i = 0; i < 3; i++) begin
      wait_req(vecs[i].addr, "tbl");
      if (i == 1) chk("throughput", 16'(cyc - t0), 16'd3);
      t0 = cyc;
      do_fetch(vecs[i]);
    end

    // Redirect in WAIT, response two cycles later is dropped.
    wait_req(16'h0006, "rw");
    step();
    a.redirect = 1'b1; a.redirect_pc = 16'h0100;
    step();
    a.redirect = 1'b0;
    step();
    a.imem_rvalid = 1'b1; a.imem_rdata = 16'hBEEF;
    step();
    a.imem_rvalid = 1'b0;
    chk1("rw_no_valid", a.inst_valid, 1'b0);
    do_fetch('{16'h0100, 16'h6001, 1, 0, 16'h0102});

    // Redirect in ISSUE then again in WAIT: one response discarded, latest target wins.
    wait_req(16'h0102, "ri");
    a.redirect = 1'b1; a.redirect_pc = 16'h0200;
    step();
    a.redirect_pc = 16'h0300;
    step();
    a.redirect = 1'b0;
    a.imem_rvalid = 1'b1; a.imem_rdata = 16'hDEAD;
    step();
    a.imem_rvalid = 1'b0;
    chk1("ri_no_valid", a.inst_valid, 1'b0);
    do_fetch('{16'h0300, 16'h6802, 1, 0, 16'h0302});

    // Redirect in OUT together with inst_ready.
    wait_req(16'h0302, "ro");
    respond(1, 16'h7003);
    chk1("ro_valid", a.inst_valid, 1'b1);
    a.redirect = 1'b1; a.redirect_pc = 16'h0040; a.inst_ready = 1'b1;
    step();
    a.redirect = 1'b0; a.inst_ready = 1'b0;
    chk1("ro_valid_drop", a.inst_valid, 1'b0);
    chk1("ro_req", a.imem_req, 1'b1);
    chk("ro_addr", a.imem_addr, 16'h0040);
    do_fetch('{16'h0040, 16'h7004, 1, 0, 16'h0042});

    // Redirect coincident with the response in WAIT.
    wait_req(16'h0042, "rc");
    step();
    a.redirect = 1'b1; a.redirect_pc = 16'h0006;
    a.imem_rvalid = 1'b1; a.imem_rdata = 16'h7777;
    step();
    a.redirect = 1'b0; a.imem_rvalid = 1'b0;
    chk1("rc_no_valid", a.inst_valid, 1'b0);
    do_fetch('{16'h0006, 16'h0000, 1, 0, 16'h0008});

    // HALT retired: fetch stops and ignores redirect and stray responses.
    chk1("halt_flag", a.halted, 1'b1);
    for (int i = 0; i < 20; i++) begin
      a.redirect    = (i == 5);
      a.redirect_pc = 16'h1234;
      a.imem_rvalid = (i == 7);
      step();
      chk1("halt_no_req", a.imem_req, 1'b0);
      chk1("halt_no_valid", a.inst_valid, 1'b0);
      chk1("halt_hold", a.halted, 1'b1);
    end
    a.redirect = 1'b0; a.imem_rvalid = 1'b0;
    chk("halt_pc", a.imem_addr, 16'h0008);

    // Asynchronous reset while a response is outstanding.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_req(16'h0000, "ar");
    step();
    rst_n = 1'b0;
    #1;
    chk1("ar_req", a.imem_req, 1'b0);
    chk1("ar_halted", a.halted, 1'b0);
    chk1("ar_valid", a.inst_valid, 1'b0);
    chk("ar_inst", a.inst, 16'h0800);
    chk("ar_inst_pc", a.inst_pc, 16'h0000);
    step();
    a.imem_rvalid = 1'b1; a.imem_rdata = 16'h1234;
    step();
    a.imem_rvalid = 1'b0;
    rst_n = 1'b1;
    do_fetch('{16'h0000, 16'h4000, 1, 0, 16'h0002});

    // Wrap-around from RESET_PC = FFFE.
    rst_n_w = 1'b1;
    n = 0;
    while (!b.imem_req && n < 30) begin
      step();
      n++;
    end
    chk1("wrap_req0", b.imem_req, 1'b1);
    chk("wrap_addr0", b.imem_addr, 16'hFFFE);
    step();
    b.imem_rvalid = 1'b1; b.imem_rdata = 16'h4000;
    step();
    b.imem_rvalid = 1'b0;
    chk1("wrap_valid", b.inst_valid, 1'b1);
    chk("wrap_inst_pc", b.inst_pc, 16'hFFFE);
    chk("wrap_pc_plus2", b.pc_plus2, 16'h0000);
    b.inst_ready = 1'b1;
    step();
    b.inst_ready = 1'b0;
    chk1("wrap_req1", b.imem_req, 1'b1);
    chk("wrap_addr1", b.imem_addr, 16'h0000);

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
